// File: rtl/lsu_access_ctrl.sv
// Load/store sequencer between the RV64I execute stage and a 64-bit aligned data bus.
// Handles endian byte reordering, lane strobes, two-beat splitting and load extension.
module lsu_access_ctrl #(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic                  req_big,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [63:0]           req_wdata,
  output logic                  mem_req,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wstrb,
  output logic [63:0]           mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [63:0]           mem_rdata,
  output logic                  rsp_valid,
  output logic [63:0]           rsp_rdata
);

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t                  state, state_nx;
  logic                    acc_we, acc_uns, acc_big;
  logic [1:0]              acc_size;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [63:0]             acc_wdata;
  logic [63:0]             buf0;

  logic                    accept;
  logic                    sel_we, sel_big;
  logic [1:0]              sel_size;
  logic [ADDR_WIDTH-1:0]   sel_addr, base_addr;
  logic [63:0]             sel_wdata;
  logic [15:0]             lane_mask;
  logic [127:0]            store_win, rd_win;
  logic                    split;
  logic [63:0]             load_val;

  logic                    req_nx, we_nx, rsp_valid_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [7:0]              strb_nx;
  logic [63:0]             wdata_nx, rsp_rdata_nx;

  // Lanes touched across a 16-byte window starting at the beat-0 base.
  function automatic logic [15:0] lane_mask_f(input logic [1:0] size, input logic [2:0] off);
    logic [3:0]  n;
    logic [15:0] ones;
    n    = 4'd1 << size;
    ones = (16'd1 << n) - 16'd1;
    return ones << off;
  endfunction

  function automatic logic [127:0] steer_store(input logic [63:0] wd, input logic [1:0] size,
                                               input logic big, input logic [2:0] off);
    logic [127:0] w;
    logic [3:0]   n, k4, p;
    w = '0;
    n = 4'd1 << size;
    for (int k = 0; k < 8; k++) begin
      k4 = 4'(k);
      if (k4 < n) begin
        p = {1'b0, off} + (big ? (n - 4'd1 - k4) : k4);
        w[{p, 3'b000} +: 8] = wd[8*k +: 8];
      end
    end
    return w;
  endfunction

  function automatic logic [63:0] gather_load(input logic [127:0] win, input logic [1:0] size,
                                              input logic big, input logic [2:0] off);
    logic [63:0] v;
    logic [3:0]  n, k4, p;
    v = '0;
    n = 4'd1 << size;
    for (int k = 0; k < 8; k++) begin
      k4 = 4'(k);
      if (k4 < n) begin
        p = {1'b0, off} + (big ? (n - 4'd1 - k4) : k4);
        v[8*k +: 8] = win[{p, 3'b000} +: 8];
      end
    end
    return v;
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] v, input logic [1:0] size,
                                              input logic uns);
    logic [63:0] r;
    r = v;
    if (!uns) begin
      case (size)
        2'd0:    r = {{56{v[7]}},  v[7:0]};
        2'd1:    r = {{48{v[15]}}, v[15:0]};
        2'd2:    r = {{32{v[31]}}, v[31:0]};
        default: r = v;
      endcase
    end
    return r;
  endfunction

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  // Live request while idle (beat 0 is launched on the accept edge), latched copy afterwards.
  assign sel_we    = (state == IDLE) ? req_we    : acc_we;
  assign sel_size  = (state == IDLE) ? req_size  : acc_size;
  assign sel_big   = (state == IDLE) ? req_big   : acc_big;
  assign sel_addr  = (state == IDLE) ? req_addr  : acc_addr;
  assign sel_wdata = (state == IDLE) ? req_wdata : acc_wdata;

  assign base_addr = {sel_addr[ADDR_WIDTH-1:3], 3'b000};
  assign lane_mask = lane_mask_f(sel_size, sel_addr[2:0]);
  assign store_win = steer_store(sel_wdata, sel_size, sel_big, sel_addr[2:0]);
  assign split     = |lane_mask[15:8];

  assign rd_win   = {mem_rdata, (state == WAIT0) ? mem_rdata : buf0};
  assign load_val = extend_load(gather_load(rd_win, acc_size, acc_big, acc_addr[2:0]),
                                acc_size, acc_uns);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = REQ0;
      REQ0:    if (mem_gnt) state_nx = acc_we ? (split ? REQ1 : RESP) : WAIT0;
      WAIT0:   if (mem_rvalid) state_nx = split ? REQ1 : RESP;
      REQ1:    if (mem_req && mem_gnt) state_nx = acc_we ? RESP : WAIT1;
      WAIT1:   if (mem_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // REQ1 spends its first cycle with mem_req low so consecutive beats never share a grant.
  always_comb begin
    req_nx       = mem_req;
    we_nx        = mem_we;
    addr_nx      = mem_addr;
    strb_nx      = mem_wstrb;
    wdata_nx     = mem_wdata;
    rsp_valid_nx = 1'b0;
    rsp_rdata_nx = rsp_rdata;
    case (state)
      IDLE: begin
        if (accept) begin
          req_nx   = 1'b1;
          we_nx    = sel_we;
          addr_nx  = base_addr;
          strb_nx  = lane_mask[7:0];
          wdata_nx = sel_we ? store_win[63:0] : '0;
        end
      end
      REQ0: begin
        if (mem_gnt) req_nx = 1'b0;
      end
      REQ1: begin
        if (!mem_req) begin
          req_nx   = 1'b1;
          addr_nx  = base_addr + ADDR_WIDTH'(8);
          strb_nx  = lane_mask[15:8];
          wdata_nx = acc_we ? store_win[127:64] : '0;
        end else if (mem_gnt) begin
          req_nx = 1'b0;
        end
      end
      default: ;
    endcase
    if (state_nx == RESP) begin
      rsp_valid_nx = 1'b1;
      rsp_rdata_nx = acc_we ? '0 : load_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wstrb <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_req   <= req_nx;
      mem_we    <= we_nx;
      mem_addr  <= addr_nx;
      mem_wstrb <= strb_nx;
      mem_wdata <= wdata_nx;
      rsp_valid <= rsp_valid_nx;
      rsp_rdata <= rsp_rdata_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_we    <= req_we;
      acc_size  <= req_size;
      acc_uns   <= req_unsigned;
      acc_big   <= req_big;
      acc_addr  <= req_addr;
      acc_wdata <= req_wdata;
    end
    if (state == WAIT0 && mem_rvalid) buf0 <= mem_rdata;
  end

endmodule
